// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty scheduler and the PWM comparator core.
// Build option: PWM_SLEW_LIMIT_EN enables per-period slew limiting of the
// active duties; without it every apply is a single-step load.
package pwm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_APPLY = 2'd2
  } pwm_state_e;

  localparam int         NCH        = 3;
  localparam logic [1:0] CHAN_BCAST = 2'd3;

  // Prescaler divisors for the 960 Hz PWM tick and the 50 Hz servo frame.
  localparam int PRESCALE_960HZ = 10416;
  localparam int PRESCALE_50HZ  = 200000;

`ifdef PWM_SLEW_LIMIT_EN
  localparam bit SLEW_LIMIT_EN = 1'b1;
`else
  localparam bit SLEW_LIMIT_EN = 1'b0;
`endif

  // True when a request on chan addresses channel idx (broadcast hits all).
  function automatic logic chan_hit(input logic [1:0] chan, input int idx);
    logic [1:0] idx_b;
    idx_b = idx[1:0];
    return (chan == CHAN_BCAST) || (chan == idx_b);
  endfunction

endpackage

// File: rtl/pwm_duty_slew.sv
// Per-channel active-duty register. On load it moves toward the target,
// either in one step or (with PWM_SLEW_LIMIT_EN) by at most STEP, stopping
// exactly on the target. duty_nxt exposes the value the register takes at
// the next edge so the scheduler can decide whether work remains.
module pwm_duty_slew
  import pwm_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] duty,
  output logic [WIDTH-1:0] duty_nxt
);

  logic [WIDTH-1:0] step_val;

  if (SLEW_LIMIT_EN && (STEP > 0)) begin : g_slew
    localparam logic [WIDTH:0]   STEP_W = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] STEP_N = WIDTH'(STEP);
    logic [WIDTH:0] cur_w, tgt_w, up_w, lim_w;

    // Widened arithmetic so cur+STEP and tgt+STEP cannot wrap; saturate on target.
    always_comb begin
      cur_w    = {1'b0, duty};
      tgt_w    = {1'b0, target};
      up_w     = cur_w + STEP_W;
      lim_w    = tgt_w + STEP_W;
      step_val = target;
      if (cur_w < tgt_w) begin
        if (up_w < tgt_w) step_val = up_w[WIDTH-1:0];
      end else if (cur_w > lim_w) begin
        step_val = duty - STEP_N;
      end
    end
  end else begin : g_load
    assign step_val = target;
  end

  assign duty_nxt = load ? step_val : duty;

  // Active duty register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) duty <= '0;
    else        duty <= duty_nxt;
  end

endmodule

// File: rtl/pwm_duty_scheduler.sv
// Duty-cycle update scheduler for the 3-channel PWM generator. Requests are
// clamped and stored as targets; targets reach the active duty registers only
// in APPLY, which is entered on a period boundary so no period is glitched.
// Build option: PWM_SLEW_LIMIT_EN (see pwm_pkg / pwm_duty_slew).
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  ST_IDLE  | all targets applied, waiting for a request
//  ST_WAIT  | targets differ (or were rewritten), waiting for period_start
//  ST_APPLY | one cycle moving active duties toward targets; no accepts
module pwm_duty_scheduler
  import pwm_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_DUTY = 100,
  parameter int STEP     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_chan,
  input  logic [WIDTH-1:0] cfg_duty,
  input  logic             period_start,
  output logic [WIDTH-1:0] duty0,
  output logic [WIDTH-1:0] duty1,
  output logic [WIDTH-1:0] duty2,
  output logic             pending
);

  localparam logic [WIDTH-1:0] MAX_DUTY_W = WIDTH'(MAX_DUTY);

  pwm_state_e       state_q, state_d;
  logic             run_q;
  logic             accept, go_apply, apply_en, pending_nxt;
  logic [WIDTH-1:0] duty_clamped;
  logic [NCH-1:0]   hit, load, skip_d, skip_q;
  logic [WIDTH-1:0] target_q [NCH];
  logic [WIDTH-1:0] duty_q   [NCH];
  logic [WIDTH-1:0] duty_nxt [NCH];

  assign accept       = cfg_valid && cfg_ready;
  assign go_apply     = (state_q == ST_WAIT) && period_start && ena;
  assign duty_clamped = (cfg_duty > MAX_DUTY_W) ? MAX_DUTY_W : cfg_duty;

  // Channel decode, and which channels a request coinciding with the
  // boundary was written to: those must wait for the following boundary.
  always_comb begin
    hit    = '0;
    skip_d = '0;
    for (int i = 0; i < NCH; i++) begin
      hit[i]    = chan_hit(cfg_chan, i);
      skip_d[i] = go_apply && accept && hit[i];
    end
  end

  // Pending now, and pending after this cycle's apply (decides APPLY exit).
  always_comb begin
    pending     = 1'b0;
    pending_nxt = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (target_q[i] != duty_q[i])   pending     = 1'b1;
      if (target_q[i] != duty_nxt[i]) pending_nxt = 1'b1;
    end
  end

  // Holds cfg_ready low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  // Target registers; last accepted write per channel wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) target_q[i] <= '0;
      skip_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (accept && hit[i]) target_q[i] <= duty_clamped;
      end
      skip_q <= skip_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; with ena low every state holds.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_WAIT;
      ST_WAIT:  if (go_apply) state_d = ST_APPLY;
      ST_APPLY: if (ena) state_d = pending_nxt ? ST_WAIT : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: handshake ready and per-channel apply strobes.
  always_comb begin
    cfg_ready = ena && run_q && (state_q != ST_APPLY);
    apply_en  = (state_q == ST_APPLY) && ena;
    load      = '0;
    for (int i = 0; i < NCH; i++) load[i] = apply_en && !skip_q[i];
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    pwm_duty_slew #(
      .WIDTH (WIDTH),
      .STEP  (STEP)
    ) u_slew (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load[g]),
      .target   (target_q[g]),
      .duty     (duty_q[g]),
      .duty_nxt (duty_nxt[g])
    );
  end

  assign duty0 = duty_q[0];
  assign duty1 = duty_q[1];
  assign duty2 = duty_q[2];

endmodule

// File: tb/tb_pwm_duty_scheduler.sv
// Directed bench for pwm_duty_scheduler (WIDTH=8, MAX_DUTY=100, STEP=4).
// Expected values below are worked out by hand for both builds.
module tb_pwm_duty_scheduler;

  logic       clk = 1'b0;
  logic       rst_n, ena, cfg_valid, cfg_ready, period_start, pending;
  logic [1:0] cfg_chan;
  logic [7:0] cfg_duty, duty0, duty1, duty2;

  int n_cmp = 0;
  int n_err = 0;

`ifdef PWM_SLEW_LIMIT_EN
  localparam logic [7:0] E2_D1   = 8'd4;    // 0 -> 60, first step
  localparam logic       E2_PEND = 1'b1;
  localparam logic [7:0] E3_D0   = 8'd4;    // 0 -> 100
  localparam logic [7:0] E3_D1   = 8'd64;   // 60 -> 100
  localparam logic       E3_PEND = 1'b1;
  localparam logic [7:0] E4_D0   = 8'd96;   // 100 -> 30
  localparam logic [7:0] E4_D1   = 8'd96;   // 100 -> 50
  localparam logic [7:0] E5_D2   = 8'd4;    // 0 -> 10
  localparam logic       E5_PEND = 1'b1;
`else
  localparam logic [7:0] E2_D1   = 8'd60;
  localparam logic       E2_PEND = 1'b0;
  localparam logic [7:0] E3_D0   = 8'd100;
  localparam logic [7:0] E3_D1   = 8'd100;
  localparam logic       E3_PEND = 1'b0;
  localparam logic [7:0] E4_D0   = 8'd30;
  localparam logic [7:0] E4_D1   = 8'd50;
  localparam logic [7:0] E5_D2   = 8'd10;
  localparam logic       E5_PEND = 1'b0;
`endif

  pwm_duty_scheduler #(.WIDTH(8), .MAX_DUTY(100), .STEP(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_chan     (cfg_chan),
    .cfg_duty     (cfg_duty),
    .period_start (period_start),
    .duty0        (duty0),
    .duty1        (duty1),
    .duty2        (duty2),
    .pending      (pending)
  );

  always #5 clk = ~clk;

  // All tasks start and end 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [1:0] chan, input logic [7:0] duty);
    cfg_valid = 1'b1;
    cfg_chan  = chan;
    cfg_duty  = duty;
    tick();
    cfg_valid = 1'b0;
  endtask

  // Boundary pulse, then the APPLY cycle; ends with the applied duties visible.
  task automatic pulse();
    period_start = 1'b1;
    tick();
    period_start = 1'b0;
    tick();
  endtask

  task automatic settle();
    for (int k = 0; k < 40 && pending; k++) pulse();
    n_cmp++;
    if (pending !== 1'b0) begin
      n_err++;
      $display("FAIL settle: pending still %b after 40 boundaries, want 0", pending);
    end
  endtask

  task automatic do_reset();
    cfg_valid = 1'b0; period_start = 1'b0; ena = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 6; k++) begin
      ena          = 1'($urandom);
      cfg_valid    = 1'($urandom);
      cfg_chan     = 2'($urandom);
      cfg_duty     = 8'($urandom);
      period_start = 1'($urandom);
      tick();
      n_cmp++;
      if ({duty0, duty1, duty2, cfg_ready, pending} !== 26'd0) begin
        n_err++;
        $display("FAIL reset_hold: d0=%0d d1=%0d d2=%0d rdy=%b pend=%b, want all 0",
                 duty0, duty1, duty2, cfg_ready, pending);
      end
    end
    ena = 1'b1; cfg_valid = 1'b0; period_start = 1'b0;
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (cfg_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_release_rdy: got %b want 0", cfg_ready);
    end
    tick();
    n_cmp++;
    if (cfg_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_ready_next: got %b want 1", cfg_ready);
    end
  endtask

  task automatic test_single_write();
    write(2'd1, 8'd60);
    n_cmp++;
    if (pending !== 1'b1 || cfg_ready !== 1'b1 || duty1 !== 8'd0) begin
      n_err++;
      $display("FAIL write_wait: pend=%b rdy=%b d1=%0d, want 1 1 0", pending, cfg_ready, duty1);
    end
    repeat (9) tick();
    period_start = 1'b1;
    tick();
    period_start = 1'b0;
    n_cmp++;
    if (duty1 !== 8'd0 || cfg_ready !== 1'b0) begin
      n_err++;
      $display("FAIL apply_cycle: d1=%0d rdy=%b, want 0 0", duty1, cfg_ready);
    end
    tick();
    n_cmp++;
    if (duty1 !== E2_D1 || duty0 !== 8'd0 || duty2 !== 8'd0 || pending !== E2_PEND) begin
      n_err++;
      $display("FAIL ch1_apply: d0=%0d d1=%0d d2=%0d pend=%b, want 0 %0d 0 %b",
               duty0, duty1, duty2, pending, E2_D1, E2_PEND);
    end
    settle();
    n_cmp++;
    if (duty1 !== 8'd60) begin
      n_err++; $display("FAIL ch1_final: d1=%0d want 60", duty1);
    end
  endtask

  task automatic test_broadcast_clamp();
    write(2'd3, 8'd200);
    n_cmp++;
    if (pending !== 1'b1) begin
      n_err++; $display("FAIL bcast_pending: got %b want 1", pending);
    end
    pulse();
    n_cmp++;
    if (duty0 !== E3_D0 || duty1 !== E3_D1 || duty2 !== E3_D0 || pending !== E3_PEND) begin
      n_err++;
      $display("FAIL bcast_apply: d0=%0d d1=%0d d2=%0d pend=%b, want %0d %0d %0d %b",
               duty0, duty1, duty2, pending, E3_D0, E3_D1, E3_D0, E3_PEND);
    end
    settle();
    n_cmp++;
    if (duty0 !== 8'd100 || duty1 !== 8'd100 || duty2 !== 8'd100) begin
      n_err++;
      $display("FAIL bcast_clamp: d0=%0d d1=%0d d2=%0d, want 100 100 100", duty0, duty1, duty2);
    end
  endtask

  task automatic test_same_cycle_accept();
    // From IDLE: request and boundary together; boundary is missed.
    cfg_valid = 1'b1; cfg_chan = 2'd0; cfg_duty = 8'd30; period_start = 1'b1;
    tick();
    cfg_valid = 1'b0; period_start = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (duty0 !== 8'd100 || pending !== 1'b1) begin
      n_err++; $display("FAIL miss_boundary: d0=%0d pend=%b, want 100 1", duty0, pending);
    end
    pulse();
    n_cmp++;
    if (duty0 !== E4_D0) begin
      n_err++; $display("FAIL next_boundary: d0=%0d want %0d", duty0, E4_D0);
    end
    settle();
    // From WAIT: ch1 applies, ch2 written on the boundary cycle is held back.
    write(2'd1, 8'd50);
    cfg_valid = 1'b1; cfg_chan = 2'd2; cfg_duty = 8'd20; period_start = 1'b1;
    tick();
    cfg_valid = 1'b0; period_start = 1'b0;
    tick();
    n_cmp++;
    if (duty0 !== 8'd30 || duty1 !== E4_D1 || duty2 !== 8'd100 || pending !== 1'b1) begin
      n_err++;
      $display("FAIL wait_skip: d0=%0d d1=%0d d2=%0d pend=%b, want 30 %0d 100 1",
               duty0, duty1, duty2, pending, E4_D1);
    end
    settle();
    n_cmp++;
    if (duty1 !== 8'd50 || duty2 !== 8'd20) begin
      n_err++; $display("FAIL wait_skip_final: d1=%0d d2=%0d, want 50 20", duty1, duty2);
    end
  endtask

  task automatic test_slew();
    do_reset();
    write(2'd2, 8'd10);
    pulse();
    n_cmp++;
    if (duty2 !== E5_D2 || pending !== E5_PEND) begin
      n_err++;
      $display("FAIL slew_step1: d2=%0d pend=%b, want %0d %b", duty2, pending, E5_D2, E5_PEND);
    end
`ifdef PWM_SLEW_LIMIT_EN
    pulse();
    n_cmp++;
    if (duty2 !== 8'd8 || pending !== 1'b1) begin
      n_err++; $display("FAIL slew_step2: d2=%0d pend=%b, want 8 1", duty2, pending);
    end
    pulse();
    n_cmp++;
    if (duty2 !== 8'd10 || pending !== 1'b0) begin
      n_err++; $display("FAIL slew_step3: d2=%0d pend=%b, want 10 0", duty2, pending);
    end
`endif
    pulse();
    n_cmp++;
    if (duty2 !== 8'd10 || cfg_ready !== 1'b1) begin
      n_err++; $display("FAIL idle_ignore: d2=%0d rdy=%b, want 10 1", duty2, cfg_ready);
    end
  endtask

  task automatic test_freeze_and_reset();
    do_reset();
    write(2'd0, 8'd3);
    ena = 1'b0;
    cfg_valid = 1'b1; cfg_chan = 2'd1; cfg_duty = 8'd77;
    #1;
    n_cmp++;
    if (cfg_ready !== 1'b0) begin
      n_err++; $display("FAIL freeze_ready: got %b want 0", cfg_ready);
    end
    repeat (3) pulse();
    cfg_valid = 1'b0;
    ena = 1'b1;
    #1;
    n_cmp++;
    if (duty0 !== 8'd0 || duty1 !== 8'd0 || pending !== 1'b1) begin
      n_err++;
      $display("FAIL freeze_hold: d0=%0d d1=%0d pend=%b, want 0 0 1", duty0, duty1, pending);
    end
    tick();
    pulse();
    n_cmp++;
    if (duty0 !== 8'd3 || duty1 !== 8'd0 || pending !== 1'b0) begin
      n_err++;
      $display("FAIL unfreeze_apply: d0=%0d d1=%0d pend=%b, want 3 0 0", duty0, duty1, pending);
    end
    // Reset asserted in the middle of an APPLY cycle.
    write(2'd1, 8'd3);
    pulse();
    write(2'd1, 8'd1);
    period_start = 1'b1;
    tick();
    period_start = 1'b0;
    n_cmp++;
    if (cfg_ready !== 1'b0 || pending !== 1'b1 || duty0 !== 8'd3 || duty1 !== 8'd3) begin
      n_err++;
      $display("FAIL pre_reset_apply: rdy=%b pend=%b d0=%0d d1=%0d, want 0 1 3 3",
               cfg_ready, pending, duty0, duty1);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({duty0, duty1, duty2, cfg_ready, pending} !== 26'd0) begin
      n_err++;
      $display("FAIL async_reset: d0=%0d d1=%0d d2=%0d rdy=%b pend=%b, want all 0",
               duty0, duty1, duty2, cfg_ready, pending);
    end
    tick();
    rst_n = 1'b1;
    tick();
    pulse();
    n_cmp++;
    if (duty1 !== 8'd0 || pending !== 1'b0 || cfg_ready !== 1'b1) begin
      n_err++;
      $display("FAIL post_reset_idle: d1=%0d pend=%b rdy=%b, want 0 0 1", duty1, pending, cfg_ready);
    end
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; cfg_valid = 1'b0; cfg_chan = 2'd0;
    cfg_duty = 8'd0; period_start = 1'b0;
    tick();
    test_reset();
    test_single_write();
    test_broadcast_clamp();
    test_same_cycle_accept();
    test_slew();
    test_freeze_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
